// File: rtl/maxpool_stream.sv
// rtl/maxpool_stream.sv - 2x2 stride-2 streaming max-pool for one feature-map channel
module maxpool_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int HALF  = IMG_W / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  generate
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_width
      $error("maxpool_stream: IMG_W must be even and at least 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_height
      $error("maxpool_stream: IMG_H must be even and at least 2");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] pmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic a_gt;
    if (SIGNED) a_gt = $signed(a) > $signed(b);
    else        a_gt = a > b;
    return a_gt ? a : b;
  endfunction

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] pair;
  logic [DATA_W-1:0] linebuf [HALF];

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              lb_we;
  logic [IDX_W-1:0]  lb_idx;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;

  // Stalled output register blocks every pixel, even ones that would not produce output.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign lb_idx   = IDX_W'(col >> 1);
  assign pair_max = pmax(pair, in_data);
  assign win_max  = pmax(pair_max, linebuf[lb_idx]);
  assign lb_we    = accept && col[0] && !row[0];

  // Line buffer is always written on the even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= pair_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      pair      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          pair <= in_data;
        end else if (row[0]) begin
          out_data  <= win_max;
          out_valid <= 1'b1;
          out_last  <= row_last && col_last;
        end
      end
    end
  end

endmodule
